// File: rtl/pov_pkg.sv
// rtl/pov_pkg.sv - shared POV display types and default geometry
package pov_pkg;

  // Column geometry shared with the string loader and the display RAM
  localparam int POV_NUM_COLS_LOG2 = 6;
  localparam int POV_LED_W         = 8;

  // Scheduler state encoding
  typedef logic [2:0] pov_state_t;

  localparam pov_state_t ST_IDLE      = 3'd0;
  localparam pov_state_t ST_WAIT_SYNC = 3'd1;
  localparam pov_state_t ST_FETCH     = 3'd2;
  localparam pov_state_t ST_LATCH     = 3'd3;
  localparam pov_state_t ST_HOLD      = 3'd4;

endpackage

// File: rtl/pov_period_meter.sv
// rtl/pov_period_meter.sv - hall edge detect, rotation period measurement and noise filter
module pov_period_meter #(
  parameter int PER_W      = 24,
  parameter int MIN_PERIOD = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hall_pulse,
  output logic             edge_ok,
  output logic [PER_W-1:0] period_reg,
  output logic             period_valid
);

  logic             hall_q;
  logic [PER_W-1:0] count;
  logic             hall_rise;

  // A rise closer than MIN_PERIOD to the last accepted one is treated as noise
  assign hall_rise = hall_pulse & ~hall_q;
  assign edge_ok   = hall_rise && (count >= PER_W'(MIN_PERIOD));

  // Count clocks between accepted edges; a saturated count means the rotor stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      hall_q       <= 1'b0;
      count        <= '0;
      period_reg   <= '0;
      period_valid <= 1'b0;
    end else begin
      hall_q <= hall_pulse;
      if (edge_ok) begin
        period_reg   <= count;
        period_valid <= 1'b1;
        count        <= PER_W'(1);
      end else if (&count) begin
        period_valid <= 1'b0;
      end else begin
        count <= count + PER_W'(1);
      end
    end
  end

endmodule

// File: rtl/pov_column_scheduler.sv
// rtl/pov_column_scheduler.sv - splits each revolution into column slots and drives the LED bar
module pov_column_scheduler
  import pov_pkg::*;
#(
  parameter int NUM_COLS_LOG2 = POV_NUM_COLS_LOG2,
  parameter int LED_W         = POV_LED_W,
  parameter int PER_W         = 24,
  parameter int MIN_PERIOD    = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     hall_pulse,
  input  logic                     ram_busy,
  output logic                     ram_rd,
  output logic [NUM_COLS_LOG2-1:0] ram_addr,
  input  logic [LED_W-1:0]         ram_data,
  output logic [LED_W-1:0]         leds,
  output logic                     frame_start,
  output logic                     period_valid,
  output logic [NUM_COLS_LOG2-1:0] col_idx
);

  pov_state_t               state;
  logic [NUM_COLS_LOG2-1:0] col;
  logic [PER_W-1:0]         slot_cnt;
  logic [PER_W-1:0]         slot_len;
  logic [PER_W-1:0]         period_reg;
  logic                     edge_ok;
  logic                     abort;

  pov_period_meter #(
    .PER_W      (PER_W),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_meter (
    .clk          (clk),
    .rst          (rst),
    .hall_pulse   (hall_pulse),
    .edge_ok      (edge_ok),
    .period_reg   (period_reg),
    .period_valid (period_valid)
  );

  // Losing the enable, the RAM or a trustworthy period all drop the display
  assign abort = ~enable | ram_busy | ~period_valid;

  // The read strobe is gated so the loader never sees a read while it owns the RAM
  assign ram_rd      = (state == ST_FETCH) & ~abort;
  assign ram_addr    = col;
  assign col_idx     = col;
  assign frame_start = (state == ST_FETCH) && (col == '0);

  // Column sequencing: abort beats resync, resync beats the normal slot walk
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      col      <= '0;
      slot_cnt <= '0;
      slot_len <= '0;
      leds     <= '0;
    end else if ((state != ST_IDLE) && abort) begin
      state <= ST_IDLE;
      leds  <= '0;
    end else if (state == ST_IDLE) begin
      leds <= '0;
      if (enable && period_valid && !ram_busy) begin
        state <= ST_WAIT_SYNC;
      end
    end else if (edge_ok) begin
      state    <= ST_FETCH;
      col      <= '0;
      slot_cnt <= '0;
    end else begin
      case (state)
        ST_WAIT_SYNC: ;
        ST_FETCH: begin
          // Slot length is frozen per column so a new period applies at the next boundary
          slot_len <= period_reg >> NUM_COLS_LOG2;
          slot_cnt <= slot_cnt + PER_W'(1);
          state    <= ST_LATCH;
        end
        ST_LATCH: begin
          leds     <= ram_data;
          slot_cnt <= slot_cnt + PER_W'(1);
          state    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (slot_cnt >= slot_len - PER_W'(1)) begin
            if (&col) begin
              leds  <= '0;
              state <= ST_WAIT_SYNC;
            end else begin
              col      <= col + NUM_COLS_LOG2'(1);
              slot_cnt <= '0;
              state    <= ST_FETCH;
            end
          end else begin
            slot_cnt <= slot_cnt + PER_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pov_column_scheduler.sv
// tb/tb_pov_column_scheduler.sv - self-checking bench for the POV column scheduler
module tb_pov_column_scheduler;
  import pov_pkg::*;

  localparam int NCL     = 2;
  localparam int LW      = 8;
  localparam int PW      = 8;
  localparam int MINP    = 16;
  localparam int NCOLS   = 1 << NCL;
  localparam int CNT_MAX = (1 << PW) - 1;
  localparam int DIRECTED_END = 940;
  localparam int RANDOM_END   = 5000;

  typedef struct {
    int at;
    int leds;
    int fs;
    int rd;
    int col;
    int pv;
    int st;
    int preg;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           enable = 1'b0;
  logic           hall_pulse = 1'b0;
  logic           ram_busy = 1'b0;
  logic           ram_rd;
  logic [NCL-1:0] ram_addr;
  logic [LW-1:0]  ram_data;
  logic [LW-1:0]  leds;
  logic           frame_start;
  logic           period_valid;
  logic [NCL-1:0] col_idx;
  logic [LW-1:0]  mem [0:NCOLS-1];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int hits   = 0;
  vec_t vq[$];
  int edges[$];

  // reference model: meter plus a time-stamped view of which column is shown
  int m_cnt, m_per, m_mode, m_col, m_fetch, m_len, m_shown;
  bit m_hq, m_pv;
  bit cur_r, cur_en, cur_h, cur_b;

  // random stimulus state
  int hi_left, gap_left, busy_left, dis_left, sel;
  bit rr, ren, rh, rb;

  pov_column_scheduler #(
    .NUM_COLS_LOG2 (NCL),
    .LED_W         (LW),
    .PER_W         (PW),
    .MIN_PERIOD    (MINP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .hall_pulse   (hall_pulse),
    .ram_busy     (ram_busy),
    .ram_rd       (ram_rd),
    .ram_addr     (ram_addr),
    .ram_data     (ram_data),
    .leds         (leds),
    .frame_start  (frame_start),
    .period_valid (period_valid),
    .col_idx      (col_idx)
  );

  always #5 clk = ~clk;

  // display RAM: data appears the cycle after the read strobe
  always @(posedge clk) if (ram_rd) ram_data <= mem[ram_addr];

  task automatic check(input string name, input int at, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, at, act, exp);
  endtask

  function automatic vec_t mk(input int at, input int l, input int fs, input int rd,
                              input int col, input int pv, input int st, input int preg);
    vec_t v;
    v.at = at; v.leds = l; v.fs = fs; v.rd = rd;
    v.col = col; v.pv = pv; v.st = st; v.preg = preg;
    return v;
  endfunction

  function automatic bit hall_at(input int c);
    bit h = 1'b0;
    foreach (edges[i]) if (c >= edges[i] && c < edges[i] + 3) h = 1'b1;
    return h;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_per = 0; m_pv = 0; m_hq = 0;
    m_mode = 0; m_col = 0; m_fetch = -100; m_len = 0; m_shown = 0;
  endtask

  task automatic apply(input bit r, input bit en, input bit h, input bit b);
    bit fetch, e_rd, e_fs;
    logic [14:0] act, exp;
    rst = r; enable = en; hall_pulse = h; ram_busy = b;
    cur_r = r; cur_en = en; cur_h = h; cur_b = b;
    #1;
    fetch = (m_mode == 2) && (cyc == m_fetch);
    e_rd  = fetch && en && !b && m_pv;
    e_fs  = fetch && (m_col == 0);
    act = {leds, ram_rd, frame_start, col_idx, ram_addr, period_valid};
    exp = {8'(m_shown), e_rd, e_fs, 2'(m_col), 2'(m_col), m_pv};
    if (cyc >= 2) check("model", cyc, 32'(act), 32'(exp));
    foreach (vq[i]) begin
      if (vq[i].at == cyc) begin
        hits++;
        if (vq[i].leds >= 0) check("tab_leds", cyc, 32'(leds), vq[i].leds);
        if (vq[i].fs   >= 0) check("tab_frame_start", cyc, 32'(frame_start), vq[i].fs);
        if (vq[i].rd   >= 0) check("tab_ram_rd", cyc, 32'(ram_rd), vq[i].rd);
        if (vq[i].col  >= 0) check("tab_col_idx", cyc, 32'(col_idx), vq[i].col);
        if (vq[i].pv   >= 0) check("tab_period_valid", cyc, 32'(period_valid), vq[i].pv);
        if (vq[i].st   >= 0) check("tab_state", cyc, 32'(dut.state), vq[i].st);
        if (vq[i].preg >= 0) check("tab_period_reg", cyc, 32'(dut.u_meter.period_reg), vq[i].preg);
      end
    end
  endtask

  task automatic advance();
    bit rise, acc, ab;
    int age;
    rise = cur_h && !m_hq;
    acc  = rise && (m_cnt >= MINP);
    ab   = !cur_en || cur_b || !m_pv;
    if (cur_r) begin
      model_reset();
    end else begin
      if (m_mode != 0 && ab) begin
        m_mode = 0; m_shown = 0;
      end else if (m_mode == 0) begin
        m_shown = 0;
        if (cur_en && m_pv && !cur_b) m_mode = 1;
      end else if (acc) begin
        m_mode = 2; m_col = 0; m_fetch = cyc + 1;
      end else if (m_mode == 2) begin
        age = cyc - m_fetch;
        if (age == 0) m_len = m_per / NCOLS;
        else if (age == 1) m_shown = int'(mem[m_col[NCL-1:0]]);
        else if (age >= m_len - 1) begin
          if (m_col == NCOLS - 1) begin
            m_mode = 1; m_shown = 0;
          end else begin
            m_col++; m_fetch = cyc + 1;
          end
        end
      end
      m_hq = cur_h;
      if (acc) begin
        m_per = m_cnt; m_pv = 1; m_cnt = 1;
      end else if (m_cnt == CNT_MAX) m_pv = 0;
      else m_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    model_reset();

    edges = '{32, 96, 160, 224, 288, 293, 352, 660, 724, 788, 828, 900, 964};

    // expected checkpoints: at, leds, frame_start, ram_rd, col_idx, period_valid, state, period_reg
    vq.push_back(mk(  2, 0,     0,  0,  0,  0, ST_IDLE,      0));
    vq.push_back(mk( 97, -1,    -1, -1, -1, 1, -1,           64));
    vq.push_back(mk(161, 8'h44, 1,  1,  0,  1, ST_FETCH,     -1));
    vq.push_back(mk(162, 8'h44, 0,  0,  0,  -1, ST_LATCH,    -1));
    vq.push_back(mk(163, 8'h11, 0,  0,  0,  -1, ST_HOLD,     -1));
    vq.push_back(mk(177, 8'h11, 0,  1,  1,  -1, ST_FETCH,    -1));
    vq.push_back(mk(179, 8'h22, -1, 0,  1,  -1, -1,          -1));
    vq.push_back(mk(193, 8'h22, 0,  1,  2,  -1, -1,          -1));
    vq.push_back(mk(195, 8'h33, -1, -1, 2,  -1, -1,          -1));
    vq.push_back(mk(209, 8'h33, 0,  1,  3,  -1, -1,          -1));
    vq.push_back(mk(211, 8'h44, -1, -1, 3,  -1, -1,          -1));
    vq.push_back(mk(224, 8'h44, 0,  0,  3,  1, ST_HOLD,      64));
    vq.push_back(mk(225, -1,    1,  1,  0,  -1, ST_FETCH,    -1));
    vq.push_back(mk(227, 8'h11, -1, -1, 0,  -1, -1,          -1));
    vq.push_back(mk(291, 8'h11, -1, -1, 0,  -1, -1,          -1));
    vq.push_back(mk(294, -1,    -1, -1, 0,  -1, ST_HOLD,     64));
    vq.push_back(mk(307, 8'h22, -1, -1, 1,  -1, -1,          64));
    vq.push_back(mk(323, 8'h33, -1, -1, 2,  -1, -1,          -1));
    vq.push_back(mk(326, 0,     0,  0,  -1, -1, ST_IDLE,     -1));
    vq.push_back(mk(336, 0,     0,  0,  -1, -1, ST_WAIT_SYNC, -1));
    vq.push_back(mk(352, 0,     0,  0,  -1, -1, ST_WAIT_SYNC, -1));
    vq.push_back(mk(353, -1,    1,  1,  0,  -1, ST_FETCH,    -1));
    vq.push_back(mk(355, 8'h11, -1, -1, 0,  -1, -1,          -1));
    vq.push_back(mk(607, -1,    -1, -1, -1, 1,  -1,          -1));
    vq.push_back(mk(608, 0,     -1, -1, -1, 0,  ST_WAIT_SYNC, -1));
    vq.push_back(mk(609, 0,     -1, 0,  -1, 0,  ST_IDLE,     -1));
    vq.push_back(mk(620, 0,     0,  0,  -1, 0,  ST_IDLE,     -1));
    vq.push_back(mk(661, 0,     -1, -1, -1, 1,  ST_IDLE,     255));
    vq.push_back(mk(662, 0,     -1, -1, -1, 1,  ST_WAIT_SYNC, -1));
    vq.push_back(mk(725, -1,    1,  1,  0,  1,  ST_FETCH,    64));
    vq.push_back(mk(727, 8'h11, -1, -1, 0,  -1, -1,          -1));
    vq.push_back(mk(829, -1,    1,  1,  0,  -1, ST_FETCH,    40));
    vq.push_back(mk(831, 8'h11, -1, -1, 0,  -1, -1,          -1));
    vq.push_back(mk(839, -1,    0,  1,  1,  -1, ST_FETCH,    -1));
    vq.push_back(mk(849, -1,    0,  1,  2,  -1, ST_FETCH,    -1));
    vq.push_back(mk(859, -1,    0,  1,  3,  -1, ST_FETCH,    -1));
    vq.push_back(mk(869, 0,     -1, 0,  -1, -1, ST_WAIT_SYNC, -1));
    vq.push_back(mk(932, 0,     0,  0,  0,  0,  ST_IDLE,     0));

    @(negedge clk);

    // directed timeline: nominal, noise, preemption, stall, speed-up, mid-frame reset
    while (cyc < DIRECTED_END) begin
      apply((cyc < 2) || (cyc == 930) || (cyc == 931), 1'b1, hall_at(cyc),
            (cyc >= 325) && (cyc < 335));
      advance();
    end

    // randomized traffic checked against the model every cycle
    hi_left = 0; gap_left = 20; busy_left = 0; dis_left = 0;
    while (cyc < RANDOM_END) begin
      if (hi_left > 0) begin
        rh = 1'b1; hi_left--;
      end else if (gap_left == 0) begin
        rh = 1'b1;
        hi_left = $urandom_range(0, 2);
        sel = $urandom_range(0, 19);
        if (sel < 2) gap_left = $urandom_range(2, 12);
        else if (sel == 2) gap_left = $urandom_range(280, 320);
        else gap_left = $urandom_range(30, 130);
      end else begin
        rh = 1'b0; gap_left--;
      end
      if (busy_left > 0) begin
        rb = 1'b1; busy_left--;
      end else begin
        rb = 1'b0;
        if ($urandom_range(0, 249) == 0) busy_left = $urandom_range(1, 25);
      end
      if (dis_left > 0) begin
        ren = 1'b0; dis_left--;
      end else begin
        ren = 1'b1;
        if ($urandom_range(0, 399) == 0) dis_left = $urandom_range(1, 8);
      end
      rr = ($urandom_range(0, 1499) == 0);
      apply(rr, ren, rh, rb);
      advance();
    end

    check("table_entries_visited", cyc, hits, vq.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
